// File: rtl/lcd_hex_formatter.sv
// Serial hex-to-ASCII renderer for the 32-character LCD buffer; one digit per cycle,
// with rate-limited, handshaked refresh pulses toward the LCD driver.
module lcd_hex_formatter #(
  parameter int                  NUM_CH   = 4,
  parameter int                  DIGITS   = 8,
  parameter logic [5*NUM_CH-1:0] POS      = {5'd24, 5'd16, 5'd8, 5'd0},
  parameter int                  HOLDOFF  = 50000,
  parameter bit                  BLANK_LZ = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*4*DIGITS-1:0] vals,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic                       drv_ready,
  output logic [255:0]               strdata,
  output logic                       refresh,
  output logic                       busy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int VW = $clog2(NUM_CH * 4 * DIGITS);
  localparam int PW = (5 * NUM_CH > 1) ? $clog2(5 * NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, ISSUE} state_t;

  state_t                     state_q;
  logic [NUM_CH*4*DIGITS-1:0] snap_vals_q;
  logic [NUM_CH-1:0]          snap_en_q;
  logic                       force_q;
  logic [CW-1:0]              ch_q;
  logic [DW-1:0]              dig_q;
  logic                       nz_q;
  logic [HW-1:0]              cnt_q;
  logic [255:0]               strdata_q;
  logic                       refresh_q;
  logic                       busy_q;

  logic [VW-1:0] nib_idx;
  logic [PW-1:0] pos_idx;
  logic [3:0]    nib;
  int            pos_sum;
  logic          wr_en;
  logic [4:0]    wr_idx;
  logic [7:0]    chr;
  logic          changed;

  always_comb begin
    nib_idx = VW'(4 * DIGITS * int'(ch_q) + 4 * int'(dig_q));
    pos_idx = PW'(5 * int'(ch_q));
    nib     = snap_vals_q[nib_idx +: 4];
    pos_sum = int'(POS[pos_idx +: 5]) + int'(dig_q);
    wr_en   = (pos_sum < 32);
    wr_idx  = pos_sum[4:0];
    // nz_q tracks whether a nonzero digit has already been emitted in this channel
    if (!snap_en_q[ch_q]) begin
      chr = 8'h2D;
    end else if (BLANK_LZ && (nib == 4'h0) && !nz_q && (dig_q != '0)) begin
      chr = 8'h20;
    end else if (nib < 4'd10) begin
      chr = 8'h30 + {4'h0, nib};
    end else begin
      chr = 8'h37 + {4'h0, nib};
    end
    changed = (vals != snap_vals_q) || (ch_en != snap_en_q) || force_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_vals_q <= '0;
      snap_en_q   <= '0;
      force_q     <= 1'b1;
      ch_q        <= '0;
      dig_q       <= '0;
      nz_q        <= 1'b0;
      cnt_q       <= HW'(HOLDOFF);
      strdata_q   <= {32{8'h20}};
      refresh_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        cnt_q <= '0;
      end else if (cnt_q != HW'(HOLDOFF)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (changed) begin
            snap_vals_q <= vals;
            snap_en_q   <= ch_en;
            force_q     <= 1'b0;
            ch_q        <= '0;
            dig_q       <= DW'(DIGITS - 1);
            nz_q        <= 1'b0;
            state_q     <= SCAN;
            busy_q      <= 1'b1;
          end
        end
        SCAN: begin
          if (wr_en) begin
            strdata_q[{wr_idx, 3'b000} +: 8] <= chr;
          end
          if (dig_q == '0) begin
            dig_q <= DW'(DIGITS - 1);
            nz_q  <= 1'b0;
            if (ch_q == CW'(NUM_CH - 1)) begin
              state_q <= HOLD;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end else begin
            dig_q <= dig_q - 1'b1;
            nz_q  <= nz_q | (nib != 4'h0);
          end
        end
        HOLD: begin
          if ((cnt_q == HW'(HOLDOFF)) && drv_ready) begin
            state_q   <= ISSUE;
            refresh_q <= 1'b1;
          end
        end
        ISSUE: begin
          refresh_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          refresh_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign strdata = strdata_q;
  assign refresh = refresh_q;
  assign busy    = busy_q;

endmodule
